dmem_bus_bridge: RTL and testbench

DMEM_BUS_BRIDGE -- requirements
Module: dmem_bus_bridge

---
 rtl/dmem_bus_bridge_if.sv | 39 +++
 rtl/dmem_bus_bridge.sv | 106 ++++++++++
 tb/tb_dmem_bus_bridge.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_bus_bridge_if.sv
// Signal bundle between the memory stage, the dmem bus bridge and the data bus.
// The slave modport is the bridge's view; the master modport is its environment.
interface dmem_bus_bridge_if;
    logic        req_valid_i;
    logic        req_wen_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic [3:0]  req_strb_i;

    logic        rsp_done_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        busy_o;

    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [3:0]  bus_strb_o;

    logic        bus_gnt_i;
    logic        bus_rvalid_i;
    logic [31:0] bus_rdata_i;
    logic        bus_err_i;

    modport slave (
        input  req_valid_i, req_wen_i, req_addr_i, req_wdata_i, req_strb_i,
        input  bus_gnt_i, bus_rvalid_i, bus_rdata_i, bus_err_i,
        output rsp_done_o, rsp_rdata_o, rsp_err_o, busy_o,
        output bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_strb_o
    );

    modport master (
        output req_valid_i, req_wen_i, req_addr_i, req_wdata_i, req_strb_i,
        output bus_gnt_i, bus_rvalid_i, bus_rdata_i, bus_err_i,
        input  rsp_done_o, rsp_rdata_o, rsp_err_o, busy_o,
        input  bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_strb_o
    );
endinterface

// File: rtl/dmem_bus_bridge.sv
// Bridges single-cycle memory-stage requests onto a req/gnt + rvalid data bus,
// with a saturating timeout that abandons stalled transactions.
module dmem_bus_bridge #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic               clk_i,
    input  logic               rst_i,
    dmem_bus_bridge_if.slave   port
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [1:0]  state;
    logic [7:0]  cnt;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  strb_q;
    logic        done_q;
    logic        err_q;
    logic [31:0] rdata_q;
    logic        expired;

    assign expired = (cnt == CNT_LAST);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state   <= S_IDLE;
            cnt     <= 8'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            strb_q  <= 4'd0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            // Counter keeps running after a late grant, so a grant in the last
            // REQ cycle leaves it past CNT_LAST and RESP cannot time out again.
            if ((state == S_REQ || state == S_RESP) && cnt != 8'hFF)
                cnt <= cnt + 8'd1;
            case (state)
                S_IDLE: begin
                    if (port.req_valid_i) begin
                        we_q    <= port.req_wen_i;
                        addr_q  <= port.req_addr_i;
                        wdata_q <= port.req_wdata_i;
                        strb_q  <= port.req_strb_i;
                        cnt     <= 8'd0;
                        state   <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (port.bus_gnt_i) begin
                        state <= S_RESP;
                    end else if (expired) begin
                        done_q <= 1'b1;
                        err_q  <= 1'b1;
                        if (!we_q)
                            rdata_q <= 32'd0;
                        state  <= S_IDLE;
                    end
                end
                S_RESP: begin
                    if (port.bus_rvalid_i) begin
                        done_q <= 1'b1;
                        err_q  <= port.bus_err_i;
                        if (!we_q)
                            rdata_q <= port.bus_err_i ? 32'd0 : port.bus_rdata_i;
                        state  <= S_IDLE;
                    end else if (expired) begin
                        done_q <= 1'b1;
                        err_q  <= 1'b1;
                        if (!we_q)
                            rdata_q <= 32'd0;
                        state  <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // The abandoned response is swallowed silently.
                    if (port.bus_rvalid_i)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign port.bus_req_o   = (state == S_REQ);
    assign port.bus_we_o    = we_q;
    assign port.bus_addr_o  = addr_q;
    assign port.bus_wdata_o = wdata_q;
    assign port.bus_strb_o  = strb_q;
    assign port.busy_o      = (state != S_IDLE);
    assign port.rsp_done_o  = done_q;
    assign port.rsp_err_o   = err_q;
    assign port.rsp_rdata_o = rdata_q;

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Directed bench for dmem_bus_bridge: stimulus queues expected responses,
// a negedge monitor pops and compares them on every rsp_done_o pulse.
module tb_dmem_bus_bridge;

    logic clk;
    logic rst_n;

    dmem_bus_bridge_if bif();

    dmem_bus_bridge #(.TIMEOUT_CYCLES(8)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .port  (bif)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    rsp_t exp_q[$];
    rsp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic prev_done = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual %h required %h", name, act, req);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual %b required %b", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] rdata, input logic err);
        rsp_t e;
        e.rdata = rdata;
        e.err   = err;
        exp_q.push_back(e);
    endtask

    // Leaves the caller in cycle 1 of the transaction.
    task automatic issue(input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] strb);
        bif.req_valid_i = 1'b1;
        bif.req_wen_i   = we;
        bif.req_addr_i  = addr;
        bif.req_wdata_i = wdata;
        bif.req_strb_i  = strb;
        tick();
        bif.req_valid_i = 1'b0;
    endtask

    // Minimum-latency load; leaves the caller in cycle 3.
    task automatic load_fast(input logic [31:0] addr, input logic [31:0] rdata, input logic err);
        issue(1'b0, addr, 32'h0, 4'hF);
        chk1("fast_bus_req", bif.bus_req_o, 1'b1);
        bif.bus_gnt_i = 1'b1;
        tick();
        bif.bus_gnt_i    = 1'b0;
        bif.bus_rvalid_i = 1'b1;
        bif.bus_rdata_i  = rdata;
        bif.bus_err_i    = err;
        tick();
        bif.bus_rvalid_i = 1'b0;
        bif.bus_err_i    = 1'b0;
        bif.bus_rdata_i  = 32'h0;
        chk1("fast_done_cycle3", bif.rsp_done_o, 1'b1);
        chk1("fast_busy_cycle3", bif.busy_o, 1'b0);
    endtask

    always @(negedge clk) begin
        if (bif.rsp_done_o === 1'b1) begin
            chk1("done_back_to_back", prev_done, 1'b0);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: actual rsp_done_o=1 required 0 (nothing pending)");
            end else begin
                mon_e = exp_q.pop_front();
                chk("rsp_rdata", bif.rsp_rdata_o, mon_e.rdata);
                chk1("rsp_err", bif.rsp_err_o, mon_e.err);
            end
        end else begin
            chk1("err_without_done", bif.rsp_err_o, 1'b0);
        end
        prev_done = bif.rsp_done_o;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual timeout required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n            = 1'b0;
        bif.req_valid_i  = 1'b1;
        bif.req_wen_i    = 1'b0;
        bif.req_addr_i   = 32'h0000_1234;
        bif.req_wdata_i  = 32'h0;
        bif.req_strb_i   = 4'hF;
        bif.bus_gnt_i    = 1'b0;
        bif.bus_rvalid_i = 1'b0;
        bif.bus_rdata_i  = 32'h0;
        bif.bus_err_i    = 1'b0;

        // Reset holds everything at zero even with a request present.
        #12;
        chk1("rst_busy", bif.busy_o, 1'b0);
        chk1("rst_bus_req", bif.bus_req_o, 1'b0);
        chk1("rst_done", bif.rsp_done_o, 1'b0);
        chk("rst_rdata", bif.rsp_rdata_o, 32'h0);
        chk("rst_bus_addr", bif.bus_addr_o, 32'h0);
        bif.req_valid_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Minimum-latency load.
        push(32'hDEAD_BEEF, 1'b0);
        load_fast(32'h1000_0004, 32'hDEAD_BEEF, 1'b0);

        // Store with grant delayed four cycles; rdata must not change.
        push(32'hDEAD_BEEF, 1'b0);
        issue(1'b1, 32'h2000_0010, 32'h0000_00AB, 4'h1);
        for (int i = 0; i < 5; i++) begin
            chk1("st_bus_req", bif.bus_req_o, 1'b1);
            chk1("st_bus_we", bif.bus_we_o, 1'b1);
            chk("st_bus_addr", bif.bus_addr_o, 32'h2000_0010);
            chk("st_bus_wdata", bif.bus_wdata_o, 32'h0000_00AB);
            chk("st_bus_strb", {28'h0, bif.bus_strb_o}, 32'h1);
            bif.bus_gnt_i = (i == 4);
            tick();
        end
        bif.bus_gnt_i = 1'b0;
        chk1("st_resp_bus_req", bif.bus_req_o, 1'b0);
        chk("st_resp_wdata_held", bif.bus_wdata_o, 32'h0000_00AB);
        bif.bus_rvalid_i = 1'b1;
        bif.bus_rdata_i  = 32'h1234_5678;
        tick();
        bif.bus_rvalid_i = 1'b0;
        chk1("st_done", bif.rsp_done_o, 1'b1);

        // Bus error on a load zeroes the data.
        push(32'h0, 1'b1);
        load_fast(32'h1000_0008, 32'h5555_5555, 1'b1);
        push(32'hCAFE_F00D, 1'b0);
        load_fast(32'h1000_000C, 32'hCAFE_F00D, 1'b0);

        // Never granted: eight REQ cycles, rvalid in REQ ignored, then error.
        push(32'h0, 1'b1);
        issue(1'b0, 32'h1000_0010, 32'h0, 4'hF);
        for (int i = 0; i < 8; i++) begin
            chk1("to_req_bus_req", bif.bus_req_o, 1'b1);
            bif.bus_rvalid_i = (i == 2);
            tick();
        end
        bif.bus_rvalid_i = 1'b0;
        chk1("to_req_bus_req_drop", bif.bus_req_o, 1'b0);
        chk1("to_req_busy", bif.busy_o, 1'b0);
        chk1("to_req_done", bif.rsp_done_o, 1'b1);

        // Grant in the last REQ cycle wins over the timeout.
        push(32'h0BAD_F00D, 1'b0);
        issue(1'b0, 32'h1000_0014, 32'h0, 4'hF);
        for (int i = 0; i < 8; i++) begin
            chk1("gnt_last_bus_req", bif.bus_req_o, 1'b1);
            bif.bus_gnt_i = (i == 7);
            tick();
        end
        bif.bus_gnt_i = 1'b0;
        chk1("gnt_last_busy", bif.busy_o, 1'b1);
        chk1("gnt_last_no_done", bif.rsp_done_o, 1'b0);
        bif.bus_rvalid_i = 1'b1;
        bif.bus_rdata_i  = 32'h0BAD_F00D;
        tick();
        bif.bus_rvalid_i = 1'b0;
        chk1("gnt_last_done", bif.rsp_done_o, 1'b1);

        // rvalid in the last RESP cycle wins over the timeout.
        push(32'h1357_2468, 1'b0);
        issue(1'b0, 32'h1000_0018, 32'h0, 4'hF);
        bif.bus_gnt_i = 1'b1;
        tick();
        bif.bus_gnt_i = 1'b0;
        for (int c = 2; c < 8; c++) tick();
        bif.bus_rvalid_i = 1'b1;
        bif.bus_rdata_i  = 32'h1357_2468;
        tick();
        bif.bus_rvalid_i = 1'b0;
        chk1("rv_last_done", bif.rsp_done_o, 1'b1);

        // RESP timeout, then DRAIN until a late rvalid at cycle 20.
        push(32'h0, 1'b1);
        issue(1'b0, 32'h1000_001C, 32'h0, 4'hF);
        bif.bus_gnt_i = 1'b1;
        tick();
        bif.bus_gnt_i = 1'b0;
        for (int c = 2; c < 20; c++) begin
            chk1("drain_busy", bif.busy_o, 1'b1);
            chk1("drain_done", bif.rsp_done_o, (c == 9));
            tick();
        end
        chk1("drain_busy_c20", bif.busy_o, 1'b1);
        bif.bus_rvalid_i = 1'b1;
        bif.bus_rdata_i  = 32'hFFFF_FFFF;
        tick();
        bif.bus_rvalid_i = 1'b0;
        chk1("drain_idle", bif.busy_o, 1'b0);
        chk1("drain_no_done", bif.rsp_done_o, 1'b0);
        chk("drain_rdata", bif.rsp_rdata_o, 32'h0);

        // Request while busy is ignored; reset in RESP clears everything at once.
        push(32'h600D_CAFE, 1'b0);
        load_fast(32'h1000_0020, 32'h600D_CAFE, 1'b0);
        issue(1'b0, 32'h1000_0024, 32'h0, 4'hF);
        bif.req_valid_i = 1'b1;
        bif.req_wen_i   = 1'b1;
        bif.req_addr_i  = 32'h9999_9990;
        tick();
        bif.req_valid_i = 1'b0;
        chk1("b2b_bus_req", bif.bus_req_o, 1'b1);
        chk("b2b_bus_addr", bif.bus_addr_o, 32'h1000_0024);
        chk1("b2b_bus_we", bif.bus_we_o, 1'b0);
        bif.bus_gnt_i = 1'b1;
        tick();
        bif.bus_gnt_i = 1'b0;
        chk1("b2b_resp_busy", bif.busy_o, 1'b1);
        rst_n = 1'b0;
        #1;
        chk1("rst_resp_busy", bif.busy_o, 1'b0);
        chk("rst_resp_addr", bif.bus_addr_o, 32'h0);
        chk("rst_resp_rdata", bif.rsp_rdata_o, 32'h0);
        chk("rst_resp_strb", {28'h0, bif.bus_strb_o}, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk1("post_rst_busy", bif.busy_o, 1'b0);

        // Reset in REQ drops bus_req_o without a clock edge.
        issue(1'b1, 32'h3000_0000, 32'h0000_0077, 4'hC);
        chk1("req_rst_bus_req_before", bif.bus_req_o, 1'b1);
        rst_n = 1'b0;
        #1;
        chk1("req_rst_bus_req_after", bif.bus_req_o, 1'b0);
        chk("req_rst_wdata", bif.bus_wdata_o, 32'h0);
        tick();

        // Request accepted on the first edge after release.
        rst_n = 1'b1;
        push(32'h2468_1357, 1'b0);
        issue(1'b0, 32'h1000_0030, 32'h0, 4'hF);
        chk1("first_edge_bus_req", bif.bus_req_o, 1'b1);
        chk("first_edge_addr", bif.bus_addr_o, 32'h1000_0030);
        bif.bus_gnt_i = 1'b1;
        tick();
        bif.bus_gnt_i    = 1'b0;
        bif.bus_rvalid_i = 1'b1;
        bif.bus_rdata_i  = 32'h2468_1357;
        tick();
        bif.bus_rvalid_i = 1'b0;
        chk1("first_edge_done", bif.rsp_done_o, 1'b1);

        for (int i = 0; i < 3; i++) tick();
        chk("pending_responses", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
